systolic_driver: RTL and testbench

SYSTOLIC_DRIVER -- requirements
Module: systolic_driver

---
 rtl/systolic_driver_if.sv | 29 ++
 rtl/systolic_driver.sv | 78 +++++++
 tb/tb_systolic_driver.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_driver_if.sv
// systolic_driver_if: upstream, weight, array and downstream signals of the systolic driver
interface systolic_driver_if #(
  parameter int DATA_W  = 32,
  parameter int IN_DIM  = 2,
  parameter int OUT_DIM = 2
);
  logic                                   s_valid;
  logic                                   s_ready;
  logic [IN_DIM-1:0][DATA_W-1:0]          s_vec;
  logic                                   w_load;
  logic                                   w_ready;
  logic [OUT_DIM-1:0][IN_DIM-1:0][DATA_W-1:0] w_data;
  logic                                   sa_valid;
  logic [OUT_DIM-1:0][IN_DIM-1:0][DATA_W-1:0] sa_weights;
  logic [IN_DIM-1:0][DATA_W-1:0]          sa_vec_in;
  logic                                   sa_ready;
  logic [OUT_DIM-1:0][DATA_W-1:0]         sa_vec_out;
  logic                                   m_valid;
  logic                                   m_ready;
  logic [OUT_DIM-1:0][DATA_W-1:0]         m_vec;
  modport master (
    input  s_valid, s_vec, w_load, w_data, sa_ready, sa_vec_out, m_ready,
    output s_ready, w_ready, sa_valid, sa_weights, sa_vec_in, m_valid, m_vec
  );
  modport slave (
    output s_valid, s_vec, w_load, w_data, sa_ready, sa_vec_out, m_ready,
    input  s_ready, w_ready, sa_valid, sa_weights, sa_vec_in, m_valid, m_vec
  );
endinterface

// File: rtl/systolic_driver.sv
// systolic_driver: buffers vectors into a systolic array with credit-limited launches and a result FIFO
module systolic_driver #(
  parameter int DATA_W      = 32,
  parameter int IN_DIM      = 2,
  parameter int OUT_DIM     = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  systolic_driver_if.master  bus,
  output logic               busy,
  output logic               err_spurious
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic {IDLE, HOLD} state_t;
  typedef logic [OUT_DIM-1:0][DATA_W-1:0] res_t;
  state_t                                     state, state_nx;
  logic [HW-1:0]                              hold_cnt;
  logic                                       buf_full;
  logic [IN_DIM-1:0][DATA_W-1:0]              buf_vec, vec_in;
  logic [OUT_DIM-1:0][IN_DIM-1:0][DATA_W-1:0] weights;
  logic [CW-1:0]                              outstanding, fifo_count;
  logic [AW-1:0]                              wr_ptr, rd_ptr;
  res_t                                       mem [FIFO_DEPTH];
  logic credit_ok, launch, hold_done, take_in, push, pop;
  // a launch reserves a FIFO slot, so results in flight plus queued never exceed the depth
  assign credit_ok = {1'b0, outstanding} + {1'b0, fifo_count} < (CW + 1)'(FIFO_DEPTH);
  assign take_in   = bus.s_valid && bus.s_ready;
  assign push      = bus.sa_ready && outstanding != '0;
  assign pop       = bus.m_valid && bus.m_ready;
  assign busy      = state == HOLD || outstanding != '0 || buf_full;
  assign bus.s_ready    = !buf_full || hold_done;
  assign bus.w_ready    = !busy;
  assign bus.sa_weights = weights;
  assign bus.sa_vec_in  = vec_in;
  assign bus.m_valid    = fifo_count != '0;
  assign bus.m_vec      = mem[rd_ptr];
  always_comb begin
    hold_done    = state == HOLD && hold_cnt == HW'(HOLD_CYCLES - 1);
    launch       = state == IDLE && buf_full && credit_ok;
    state_nx     = launch ? HOLD : hold_done ? IDLE : state;
    bus.sa_valid = state == HOLD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      buf_full     <= 1'b0;
      buf_vec      <= '0;
      vec_in       <= '0;
      weights      <= '0;
      outstanding  <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_spurious <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= state == HOLD && !hold_done ? hold_cnt + 1'b1 : '0;
      buf_full    <= take_in || (buf_full && !hold_done);
      outstanding <= outstanding + CW'(launch) - CW'(push);
      fifo_count  <= fifo_count + CW'(push) - CW'(pop);
      if (take_in) buf_vec <= bus.s_vec;
      if (launch) vec_in <= buf_vec;
      if (bus.w_load && bus.w_ready) weights <= bus.w_data;
      if (push) begin
        mem[wr_ptr] <= bus.sa_vec_out;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (bus.sa_ready && outstanding == '0) err_spurious <= 1'b1;
    end
  end
endmodule

// File: tb/tb_systolic_driver.sv
// tb_systolic_driver: randomized scoreboard bench with a behavioural matrix-vector array model
module tb_systolic_driver;
  localparam int DW = 32, ID = 2, OD = 2, FD = 4, HC = 4;
  typedef logic [ID-1:0][DW-1:0]         vin_t;
  typedef logic [OD-1:0][DW-1:0]         vout_t;
  typedef logic [OD-1:0][ID-1:0][DW-1:0] w_t;

  logic clk = 0, reset = 1, busy, err_spurious;
  systolic_driver_if #(.DATA_W(DW), .IN_DIM(ID), .OUT_DIM(OD)) bus ();
  systolic_driver #(.DATA_W(DW), .IN_DIM(ID), .OUT_DIM(OD), .FIFO_DEPTH(FD), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .err_spurious(err_spurious)
  );
  always #5 clk = ~clk;

  int    n_cmp = 0, n_bad = 0, launches = 0, ndeliv = 0, cyc = 0, run = 0;
  vout_t sb[$], pend[$], last_m;
  int    due[$];
  w_t    cur_w = '0, cap_w;
  vin_t  cap_v;
  bit    stable, arr_auto = 1, rand_mr = 0;
  logic  arr_stb = 0, man_stb = 0;
  vout_t arr_out = '0, man_out = '0;
  assign bus.sa_ready   = arr_stb | man_stb;
  assign bus.sa_vec_out = man_stb ? man_out : arr_out;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vout_t matvec(w_t w, vin_t x);
    vout_t y = '0;
    for (int o = 0; o < OD; o++)
      for (int i = 0; i < ID; i++) y[o] = y[o] + w[o][i] * x[i];
    return y;
  endfunction

  function automatic vin_t rand_v();
    vin_t v;
    for (int i = 0; i < ID; i++) v[i] = $urandom;
    return v;
  endfunction

  function automatic w_t rand_w();
    w_t w;
    for (int o = 0; o < OD; o++)
      for (int i = 0; i < ID; i++) w[o][i] = $urandom;
    return w;
  endfunction

  // array model: one result per HOLD run, returned after a random latency
  initial forever begin
    @(negedge clk);
    cyc++;
    arr_stb = 0;
    if (reset) begin
      run = 0;
      pend.delete();
      due.delete();
    end else begin
      if (bus.sa_valid) begin
        if (run == 0) begin
          cap_v = bus.sa_vec_in;
          cap_w = bus.sa_weights;
          stable = 1;
          launches++;
        end else if (bus.sa_vec_in !== cap_v || bus.sa_weights !== cap_w) stable = 0;
        run++;
      end else if (run != 0) begin
        chk("sa_valid_len", run, HC);
        chk("sa_vec_stable", stable, 1);
        if (arr_auto) begin
          pend.push_back(matvec(cap_w, cap_v));
          due.push_back(cyc + $urandom_range(0, 5));
        end
        run = 0;
      end
      if (pend.size() != 0 && due[0] <= cyc) begin
        arr_stb = 1;
        arr_out = pend.pop_front();
        void'(due.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset && bus.m_valid && bus.m_ready) begin
      last_m = bus.m_vec;
      ndeliv++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL m_vec_unexpected: got %0h expected no result", bus.m_vec);
      end else chk("m_vec", bus.m_vec, sb.pop_front());
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mr) bus.m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(vin_t v);
    bus.s_vec = v;
    bus.s_valid = 1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        sb.push_back(matvec(cur_w, v));
        step();
        bus.s_valid = 0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: s_ready 0, expected 1");
    bus.s_valid = 0;
  endtask

  task automatic ret(vout_t v);
    man_out = v;
    man_stb = 1;
    step();
    man_stb = 0;
  endtask

  task automatic load(w_t w, bit ok);
    bus.w_data = w;
    bus.w_load = 1;
    @(negedge clk);
    chk("w_ready", bus.w_ready, ok);
    step();
    bus.w_load = 0;
    if (ok) cur_w = w;
    @(negedge clk);
    chk("sa_weights", bus.sa_weights, cur_w);
    step();
  endtask

  task automatic drain(int lim);
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !bus.m_valid && pend.size() == 0) begin
        step();
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
  endtask

  task automatic pulse_reset();
    reset = 1;
    step();
    reset = 0;
    sb.delete();
    cur_w = '0;
  endtask

  task automatic wait_sa_valid();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.sa_valid) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL sa_valid_timeout: got 0 expected 1");
  endtask

  initial begin
    int l0, d0;
    vin_t a, b, c, d;
    bus.s_valid = 0; bus.s_vec = '0; bus.w_load = 0; bus.w_data = '0; bus.m_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_w_ready", bus.w_ready, 1);
    chk("rst_sa_valid", bus.sa_valid, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_sa_weights", bus.sa_weights, 0);
    chk("rst_sa_vec_in", bus.sa_vec_in, 0);
    chk("rst_m_vec", bus.m_vec, 0);
    step();

    bus.m_ready = 1;
    load({32'd4, 32'd3, 32'd2, 32'd1}, 1);
    l0 = launches; d0 = ndeliv;
    send({32'd6, 32'd5});
    drain(200);
    chk("basic_m_vec", last_m, {32'd39, 32'd17});
    chk("basic_launches", launches - l0, 1);
    chk("basic_deliveries", ndeliv - d0, 1);
    chk("basic_busy_after", busy, 0);

    send(rand_v());
    wait_sa_valid();
    step();
    load({4{32'd9}}, 0);
    drain(200);
    load({4{32'd9}}, 1);

    ret(vout_t'($urandom));
    @(negedge clk);
    chk("spur_m_valid", bus.m_valid, 0);
    chk("spur_err", err_spurious, 1);
    repeat (5) step();
    @(negedge clk);
    chk("spur_err_sticky", err_spurious, 1);
    step();
    pulse_reset();
    @(negedge clk);
    chk("spur_err_cleared", err_spurious, 0);
    step();

    load(rand_w(), 1);
    bus.m_ready = 0;
    l0 = launches; d0 = ndeliv;
    fork
      for (int k = 0; k < 8; k++) send(rand_v());
    join_none
    repeat (80) @(negedge clk);
    chk("stall_launches", launches - l0, FD);
    chk("stall_s_ready", bus.s_ready, 0);
    chk("stall_m_valid", bus.m_valid, 1);
    step();
    bus.m_ready = 1;
    wait fork;
    drain(400);
    chk("stall_deliveries", ndeliv - d0, 8);
    chk("stall_err", err_spurious, 0);

    arr_auto = 0;
    bus.m_ready = 0;
    a = rand_v(); b = rand_v(); c = rand_v(); d = rand_v();
    send(a); repeat (2) step(); ret(matvec(cur_w, a));
    send(b); repeat (2) step(); ret(matvec(cur_w, b));
    send(c); repeat (2) step();
    send(d);
    man_out = matvec(cur_w, c);
    man_stb = 1;
    bus.m_ready = 1;
    step();
    man_stb = 0;
    bus.m_ready = 0;
    @(negedge clk);
    chk("coinc_launch", bus.sa_valid, 1);
    chk("coinc_m_valid", bus.m_valid, 1);
    step();
    bus.m_ready = 1;
    ret(matvec(cur_w, d));
    drain(200);
    chk("coinc_err", err_spurious, 0);

    bus.m_ready = 0;
    a = rand_v(); b = rand_v();
    send(a); repeat (2) step(); ret(matvec(cur_w, a));
    send(b); repeat (2) step(); ret(matvec(cur_w, b));
    send(rand_v());
    wait_sa_valid();
    step();
    pulse_reset();
    @(negedge clk);
    chk("mid_rst_sa_valid", bus.sa_valid, 0);
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_s_ready", bus.s_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_vec", bus.m_vec, 0);
    step();
    ret(vout_t'($urandom));
    @(negedge clk);
    chk("mid_rst_outstanding0", err_spurious, 1);
    chk("mid_rst_no_push", bus.m_valid, 0);
    step();
    pulse_reset();
    arr_auto = 1;

    load(rand_w(), 1);
    d0 = ndeliv;
    rand_mr = 1;
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) step();
      send(rand_v());
    end
    rand_mr = 0;
    step();
    bus.m_ready = 1;
    drain(2000);
    chk("rand_deliveries", ndeliv - d0, 30);
    chk("rand_err", err_spurious, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
